uart_frame_packer: RTL

UART_FRAME_PACKER -- requirements
Module: uart_frame_packer

---
 rtl/pq_uart_pkg.sv | 45 ++++
 rtl/uart_frame_packer.sv | 107 ++++++++++
 2 files changed

// File: rtl/pq_uart_pkg.sv
// Shared definitions for the telemetry UART frame packer: state encoding,
// frame geometry and the byte selection used to build each frame.
package pq_uart_pkg;

  localparam int unsigned FRAME_LEN = 6;
  localparam int unsigned SAMPLE_W  = 12;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned GAP_W     = 8;

  localparam logic [BYTE_W-1:0] HEADER_DEFAULT = 8'hAA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [SAMPLE_W-1:0] volt;
    logic [SAMPLE_W-1:0] curr;
  } sample_t;

  // Byte at position idx of the frame built from a captured sample.
  function automatic logic [BYTE_W-1:0] frame_byte(
    input logic [IDX_W-1:0]  idx,
    input logic [BYTE_W-1:0] header,
    input sample_t           smp,
    input logic [BYTE_W-1:0] chk
  );
    logic [BYTE_W-1:0] b;
    b = '0;
    case (idx)
      3'd0:    b = header;
      3'd1:    b = {4'h0, smp.volt[11:8]};
      3'd2:    b = smp.volt[7:0];
      3'd3:    b = {4'h0, smp.curr[11:8]};
      3'd4:    b = smp.curr[7:0];
      3'd5:    b = chk;
      default: b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_frame_packer.sv
// Packs a captured voltage/current sample into a 6-byte UART frame
// (header, volt hi/lo, curr hi/lo, XOR checksum) with idle gaps between bytes.
module uart_frame_packer
  import pq_uart_pkg::*;
#(
  parameter logic [7:0]  HEADER     = HEADER_DEFAULT,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sample_valid,
  input  logic [11:0] volt,
  input  logic [11:0] curr,
  output logic        sample_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        frame_done,
  output logic [7:0]  drop_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t            state;
  logic [IDX_W-1:0]  byte_idx;
  logic [GAP_W-1:0]  gap_cnt;
  sample_t           smp;
  logic [BYTE_W-1:0] chk_c;
  logic              tx_accept;
  logic              sample_accept;

  // Checksum covers the four payload bytes only; header is excluded.
  assign chk_c = {4'h0, smp.volt[11:8]} ^ smp.volt[7:0]
               ^ {4'h0, smp.curr[11:8]} ^ smp.curr[7:0];

  assign tx_accept     = tx_valid && tx_ready;
  assign sample_accept = sample_valid && sample_ready;
  // Pulses in the same cycle the transmitter takes the checksum byte.
  assign frame_done    = tx_accept && (byte_idx == LAST_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      byte_idx     <= '0;
      gap_cnt      <= '0;
      smp          <= '0;
      tx_valid     <= 1'b0;
      tx_data      <= '0;
      sample_ready <= 1'b1;
      drop_count   <= '0;
    end else begin
      if (sample_valid && !sample_ready && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end

      case (state)
        ST_IDLE: begin
          if (sample_accept) begin
            smp.volt     <= volt;
            smp.curr     <= curr;
            sample_ready <= 1'b0;
            byte_idx     <= '0;
            tx_valid     <= 1'b1;
            tx_data      <= HEADER;
            state        <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (byte_idx == LAST_IDX) begin
              byte_idx     <= '0;
              sample_ready <= 1'b1;
              state        <= ST_IDLE;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              gap_cnt  <= '0;
              state    <= ST_GAP;
            end
          end
        end

        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt  <= '0;
            tx_valid <= 1'b1;
            tx_data  <= frame_byte(byte_idx, HEADER, smp, chk_c);
            state    <= ST_SEND;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end

        default: begin
          tx_valid     <= 1'b0;
          sample_ready <= 1'b1;
          byte_idx     <= '0;
          gap_cnt      <= '0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
